wash_seq_ctrl: RTL and testbench

- Program sequencer for the washing-machine datapath: runs WASH -> RINSE -> SPIN using the per-phase durations set on the preset digit panel.
- Counts down each phase in time units and drives the motor, water-inlet, drain and door-lock actuators.
- Exports the running phase and remaining units to the display scanner.
- Handles start, pause/resume, abort and door-open interlock.

---
 rtl/wm_pkg.sv | 61 ++++++
 rtl/unit_timer.sv | 30 +++
 rtl/wash_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_wash_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine program sequencer.
// Phase codes, BCD limits, duration payload, clamp and phase-order helpers.
package wm_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE  = 3'd0,
        PH_WASH  = 3'd1,
        PH_RINSE = 3'd2,
        PH_SPIN  = 3'd3,
        PH_PAUSE = 3'd4,
        PH_DONE  = 3'd5
    } phase_e;

    typedef struct packed {
        logic [BCD_W-1:0] wash;
        logic [BCD_W-1:0] rinse;
        logic [BCD_W-1:0] spin;
    } dur_t;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // First phase after 'from' (program order) with a nonzero duration, else DONE.
    function automatic phase_e next_phase(input phase_e from, input dur_t d);
        phase_e p;
        p = PH_DONE;
        case (from)
            PH_IDLE: begin
                if (d.wash != 4'd0)       p = PH_WASH;
                else if (d.rinse != 4'd0) p = PH_RINSE;
                else if (d.spin != 4'd0)  p = PH_SPIN;
            end
            PH_WASH: begin
                if (d.rinse != 4'd0)      p = PH_RINSE;
                else if (d.spin != 4'd0)  p = PH_SPIN;
            end
            PH_RINSE: begin
                if (d.spin != 4'd0)       p = PH_SPIN;
            end
            default: p = PH_DONE;
        endcase
        return p;
    endfunction

    function automatic logic [BCD_W-1:0] dur_of(input phase_e p, input dur_t d);
        logic [BCD_W-1:0] r;
        case (p)
            PH_WASH:  r = d.wash;
            PH_RINSE: r = d.rinse;
            PH_SPIN:  r = d.spin;
            default:  r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unit_timer.sv
// Time-unit prescaler: counts 0..UNIT_CYCLES-1 while enabled, flags the wrap cycle.
// The count holds when disabled; clr has priority over en.
module unit_timer #(
    parameter int unsigned UNIT_CYCLES = 100000000,
    parameter int unsigned TW          = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam logic [TW-1:0] LAST = TW'(UNIT_CYCLES - 1);

    logic [TW-1:0] cnt_q;

    assign tick_c = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/wash_seq_ctrl.sv
// Washing-machine program sequencer: WASH -> RINSE -> SPIN countdown with
// pause/resume, abort and door interlock; actuators decoded into registers.
module wash_seq_ctrl
    import wm_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 100000000,
    parameter int unsigned TW          = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             door_closed,
    input  logic [BCD_W-1:0] d_wash,
    input  logic [BCD_W-1:0] d_rinse,
    input  logic [BCD_W-1:0] d_spin,
    output logic [PHASE_W-1:0] phase,
    output logic [BCD_W-1:0] remain,
    output logic             motor_en,
    output logic             water_in,
    output logic             drain,
    output logic             door_lock,
    output logic             done
);

    phase_e           state_q, state_d;
    phase_e           saved_q, saved_d;
    phase_e           nxt;
    dur_t             dur_q, dur_d, dur_in;
    logic [BCD_W-1:0] remain_q, remain_d;
    logic             tmr_en, tmr_clr, tick_c;
    logic             motor_d, water_d, drain_d, lock_d, done_d;

    assign dur_in = '{wash: bcd_clamp(d_wash), rinse: bcd_clamp(d_rinse), spin: bcd_clamp(d_spin)};

    unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES),
        .TW         (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tmr_en),
        .clr   (tmr_clr),
        .tick_c(tick_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PH_IDLE;
            saved_q   <= PH_IDLE;
            dur_q     <= '0;
            remain_q  <= '0;
            motor_en  <= 1'b0;
            water_in  <= 1'b0;
            drain     <= 1'b0;
            door_lock <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            dur_q     <= dur_d;
            remain_q  <= remain_d;
            motor_en  <= motor_d;
            water_in  <= water_d;
            drain     <= drain_d;
            door_lock <= lock_d;
            done      <= done_d;
        end
    end

    // Next state: abort beats pause/door-open, which beat the unit wrap
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        dur_d    = dur_q;
        remain_d = remain_q;
        tmr_en   = 1'b0;
        tmr_clr  = 1'b0;
        nxt      = PH_DONE;
        if (abort) begin
            state_d  = PH_IDLE;
            remain_d = '0;
            tmr_clr  = 1'b1;
        end else begin
            case (state_q)
                PH_IDLE, PH_DONE: begin
                    if (start && door_closed) begin
                        nxt      = next_phase(PH_IDLE, dur_in);
                        dur_d    = dur_in;
                        state_d  = nxt;
                        remain_d = dur_of(nxt, dur_in);
                        tmr_clr  = 1'b1;
                    end
                end
                PH_WASH, PH_RINSE, PH_SPIN: begin
                    if (pause || !door_closed) begin
                        state_d = PH_PAUSE;
                        saved_d = state_q;
                    end else begin
                        tmr_en = 1'b1;
                        if (tick_c) begin
                            if (remain_q == 4'd1) begin
                                nxt      = next_phase(state_q, dur_q);
                                state_d  = nxt;
                                remain_d = dur_of(nxt, dur_q);
                            end else begin
                                remain_d = remain_q - 4'd1;
                            end
                        end
                    end
                end
                PH_PAUSE: begin
                    if (pause && door_closed) begin
                        state_d = saved_q;
                    end
                end
                default: begin
                    state_d  = PH_IDLE;
                    remain_d = '0;
                    tmr_clr  = 1'b1;
                end
            endcase
        end
    end

    // Actuator decode of the upcoming state, captured alongside it
    always_comb begin
        motor_d = 1'b0;
        water_d = 1'b0;
        drain_d = 1'b0;
        lock_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            PH_WASH, PH_RINSE: begin
                motor_d = 1'b1;
                water_d = 1'b1;
                lock_d  = 1'b1;
            end
            PH_SPIN: begin
                motor_d = 1'b1;
                drain_d = 1'b1;
                lock_d  = 1'b1;
            end
            PH_PAUSE: lock_d = 1'b1;
            PH_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign phase  = state_q;
    assign remain = remain_q;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Scoreboard bench for wash_seq_ctrl: a phase/countdown model predicts every
// cycle's outputs, a negedge monitor compares; directed scenarios plus random traffic.
module tb_wash_seq_ctrl;

    localparam int UC = 4;

    logic       clk, rst_n;
    logic       start, pause, abort, door_closed;
    logic [3:0] d_wash, d_rinse, d_spin;
    logic [2:0] phase;
    logic [3:0] remain;
    logic       motor_en, water_in, drain, door_lock, done;

    wash_seq_ctrl #(.UNIT_CYCLES(UC), .TW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
        .door_closed(door_closed), .d_wash(d_wash), .d_rinse(d_rinse), .d_spin(d_spin),
        .phase(phase), .remain(remain), .motor_en(motor_en), .water_in(water_in),
        .drain(drain), .door_lock(door_lock), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [3:0] rem;
        logic [4:0] act;   // motor, water, drain, lock, done
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Behavioural model: phase number, units left, cycles into current unit
    int m_ph, m_rem, m_pre, m_saved;
    int m_dur[3];

    function automatic int clampd(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic int first_nonzero_after(input int p);
        for (int k = p; k < 3; k++) if (m_dur[k] > 0) return k + 1;
        return 5;
    endfunction

    function automatic void model_reset();
        m_ph = 0; m_rem = 0; m_pre = 0; m_saved = 0;
        for (int k = 0; k < 3; k++) m_dur[k] = 0;
    endfunction

    function automatic void enter(input int p);
        m_ph  = p;
        m_rem = (p == 5) ? 0 : m_dur[p-1];
        m_pre = 0;
    endfunction

    function automatic void model_step();
        if (abort) begin
            m_ph = 0; m_rem = 0; m_pre = 0;
        end else if (m_ph == 0 || m_ph == 5) begin
            if (start && door_closed) begin
                m_dur[0] = clampd(d_wash);
                m_dur[1] = clampd(d_rinse);
                m_dur[2] = clampd(d_spin);
                enter(first_nonzero_after(0));
            end
        end else if (m_ph >= 1 && m_ph <= 3) begin
            if (pause || !door_closed) begin
                m_saved = m_ph;
                m_ph = 4;
            end else if (m_pre == UC - 1) begin
                m_pre = 0;
                if (m_rem == 1) enter(first_nonzero_after(m_ph));
                else m_rem = m_rem - 1;
            end else begin
                m_pre = m_pre + 1;
            end
        end else if (m_ph == 4) begin
            if (pause && door_closed) m_ph = m_saved;
        end
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.ph  = 3'(m_ph);
        e.rem = 4'(m_rem);
        e.act = {(m_ph >= 1 && m_ph <= 3), (m_ph == 1 || m_ph == 2), (m_ph == 3),
                 (m_ph >= 1 && m_ph <= 4), (m_ph == 5)};
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            model_step();
            sb.push_back(model_exp());
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e, g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = '{ph: phase, rem: remain, act: {motor_en, water_in, drain, door_lock, done}};
            n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got ph=%0d rem=%0d act=%b, expected ph=%0d rem=%0d act=%b",
                         $time, g.ph, g.rem, g.act, e.ph, e.rem, e.act);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            start = 1'b0; pause = 1'b0; abort = 1'b0;
        end
    endtask

    task automatic go(input logic [3:0] w, input logic [3:0] r, input logic [3:0] s);
        d_wash = w; d_rinse = r; d_spin = s;
        start = 1'b1;
        tick(1);
    endtask

    task automatic wait_phase(input string name, input int p, input int budget, output int n);
        n = 0;
        while (int'(phase) != p && n < budget) begin
            tick(1);
            n++;
        end
        if (int'(phase) != p) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: timeout waiting for phase %0d, phase is %0d", name, p, phase);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; door_closed = 1'b1;
        d_wash = '0; d_rinse = '0; d_spin = '0;
        model_reset();
        #2;
        check("reset_state", int'({phase, remain, motor_en, water_in, drain, door_lock, done}), 0);
        rst_n = 1'b1;
        tick(2);

        // Normal run
        go(4'd2, 4'd1, 4'd3);
        check("normal_first_phase", int'(phase), 1);
        wait_phase("normal", 5, 200, n);
        check("normal_start_to_done", n, (2 + 1 + 3) * UC);

        // Zero skip
        go(4'd0, 4'd2, 4'd0);
        check("skip_rinse_direct", int'(phase), 2);
        wait_phase("skip", 5, 100, n);
        check("skip_rinse_len", n, 2 * UC);
        go(4'd0, 4'd0, 4'd0);
        check("all_zero_done", int'(phase), 5);

        // Pause and resume
        go(4'd3, 4'd0, 4'd0);
        tick(5);
        pause = 1'b1;
        tick(20);
        check("pause_phase", int'(phase), 4);
        check("pause_remain", int'(remain), 2);
        pause = 1'b1;
        tick(1);
        wait_phase("resume", 5, 100, n);
        check("wash_run_total", n + 5, 3 * UC);

        // Door interlock
        go(4'd0, 4'd0, 4'd2);
        tick(2);
        door_closed = 1'b0;
        tick(1);
        check("door_forces_pause", int'(phase), 4);
        pause = 1'b1;
        tick(2);
        check("pause_door_open_holds", int'(phase), 4);
        door_closed = 1'b1;
        tick(1);
        pause = 1'b1;
        tick(1);
        check("resume_spin", int'(phase), 3);
        abort = 1'b1;
        tick(1);
        door_closed = 1'b0;
        go(4'd2, 4'd2, 4'd2);
        check("start_door_open_ignored", int'(phase), 0);
        door_closed = 1'b1;

        // Abort and collisions
        go(4'd1, 4'd3, 4'd1);
        wait_phase("to_rinse", 2, 50, n);
        tick(3);
        abort = 1'b1;
        tick(1);
        check("abort_mid_rinse", int'({phase, remain, motor_en, water_in, drain, door_lock, done}), 0);
        go(4'd3, 4'd3, 4'd3);
        tick(2);
        abort = 1'b1; pause = 1'b1;
        tick(1);
        check("abort_beats_pause", int'(phase), 0);
        go(4'd1, 4'd0, 4'd0);
        tick(UC - 1);
        pause = 1'b1;
        tick(1);
        check("pause_on_final_wrap_phase", int'(phase), 4);
        check("pause_on_final_wrap_remain", int'(remain), 1);
        abort = 1'b1;
        tick(1);

        // Async reset mid-SPIN
        go(4'd0, 4'd0, 4'd5);
        tick(6);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({phase, remain, motor_en, water_in, drain, door_lock, done}), 0);
        sb.delete();
        model_reset();
        #1 rst_n = 1'b1;
        tick(1);

        // Clamp
        go(4'hC, 4'd0, 4'd0);
        check("clamp_remain", int'(remain), 9);
        wait_phase("clamp", 5, 100, n);
        check("clamp_len", n, 9 * UC);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            start  = ($urandom_range(0, 19) == 0);
            pause  = ($urandom_range(0, 24) == 0);
            abort  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
            d_wash  = 4'($urandom_range(0, 15));
            d_rinse = 4'($urandom_range(0, 15));
            d_spin  = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
